// File: rtl/tt_mrmola_pkg.sv
// Shared types and constants for the accumulating sum transmitter.
package tt_mrmola_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Frame payload: acc[7:0] followed by the sticky carry.
    localparam int unsigned FRAME_DATA_BITS = 9;

    localparam int unsigned CTRL_LOAD  = 0;
    localparam int unsigned CTRL_SEND  = 1;
    localparam int unsigned CTRL_CLEAR = 2;
    localparam int unsigned NUM_CTRL   = 3;

endpackage

// File: rtl/mrmola_serial_tx.sv
// UART-style transmitter: start bit, FRAME_DATA_BITS payload LSB first, stop bit.
module mrmola_serial_tx
    import tt_mrmola_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [FRAME_DATA_BITS-1:0] data,
    output logic                       tx,
    output logic                       busy
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_DATA_BITS - 1);

    tx_state_e                  state_q;
    logic [15:0]                timer_q;
    logic [3:0]                 bit_idx_q;
    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic                       tx_q;
    logic                       busy_q;
    logic                       tick_done;

    assign tick_done = (timer_q == LAST_TICK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    if (start) begin
                        state_q <= StStart;
                        shift_q <= data;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (tick_done) begin
                        state_q   <= StData;
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                StData: begin
                    if (tick_done) begin
                        timer_q <= '0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            // shift_q[0] always holds the bit currently on the wire
                            bit_idx_q <= bit_idx_q + 4'd1;
                            shift_q   <= {1'b0, shift_q[FRAME_DATA_BITS-1:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                StStop: begin
                    if (tick_done) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/tt_um_mrmola_sum_tx.sv
// Accumulating adder whose {carry, sum} is shipped out as a serial frame on request.
module tt_um_mrmola_sum_tx
    import tt_mrmola_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [NUM_CTRL-1:0] sync1_q;
    logic [NUM_CTRL-1:0] sync2_q;
    logic [NUM_CTRL-1:0] prev_q;
    logic [NUM_CTRL-1:0] armed_q;
    logic                live_q;
    logic [NUM_CTRL-1:0] rise;

    logic [7:0] acc_q;
    logic       carry_q;
    logic [8:0] sum;
    logic       send_start;
    logic       tx;
    logic       busy;

    // A strobe is armed only after a genuine low has been synchronised, so a pin
    // held high across reset release never produces an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            live_q  <= 1'b0;
        end else begin
            sync1_q <= uio_in[NUM_CTRL-1:0];
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            live_q  <= 1'b1;
            armed_q <= armed_q | ({NUM_CTRL{live_q}} & ~sync1_q);
        end
    end

    assign rise = sync2_q & ~prev_q & armed_q;
    assign sum  = {1'b0, acc_q} + {1'b0, ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (rise[CTRL_CLEAR]) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (rise[CTRL_LOAD]) begin
            acc_q   <= sum[7:0];
            carry_q <= carry_q | sum[8];
        end
    end

    assign send_start = rise[CTRL_SEND] & ~busy;

    mrmola_serial_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serial_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(send_start),
        .data ({carry_q, acc_q}),
        .tx   (tx),
        .busy (busy)
    );

    assign uo_out  = {5'b0, carry_q, busy, tx};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = ^{ena, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_mrmola_sum_tx.sv
// Directed bench for the sum transmitter with a frame-level reference model.
module tb_tt_um_mrmola_sum_tx;

    localparam int N = 16;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int errors = 0;
    int checks = 0;

    tt_um_mrmola_sum_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: strobe acts two edges after the first high sample that
    // follows a low sample taken since reset release.
    logic [2:0] hist[4];
    int         nvalid = 0;
    int         cyc = 0;
    int         m_fs = 0;
    logic [7:0] m_acc = 8'h00;
    logic       m_carry = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_tx = 1'b1;
    logic [8:0] m_snap = 9'h000;

    initial begin : model
        logic [2:0] act;
        logic       busy_before;
        int         s;
        int         idx;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_acc = 8'h00; m_carry = 1'b0; m_busy = 1'b0; m_tx = 1'b1;
                nvalid = 0;
                for (int i = 0; i < 4; i++) hist[i] = 3'b000;
            end else begin
                cyc++;
                hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0];
                hist[0] = uio_in[2:0];
                if (nvalid < 4) nvalid++;
                for (int b = 0; b < 3; b++) act[b] = (nvalid >= 4) && hist[2][b] && !hist[3][b];
                busy_before = m_busy;
                if (m_busy && (cyc - m_fs) == 11 * N) m_busy = 1'b0;
                if (act[1] && !busy_before) begin
                    m_snap = {m_carry, m_acc};
                    m_fs   = cyc;
                    m_busy = 1'b1;
                end
                if (act[2]) begin
                    m_acc = 8'h00; m_carry = 1'b0;
                end else if (act[0]) begin
                    s = int'(m_acc) + int'(ui_in);
                    m_acc = s[7:0];
                    m_carry = m_carry | (s > 255);
                end
                if (!m_busy) m_tx = 1'b1;
                else begin
                    idx = (cyc - m_fs) / N;
                    if (idx == 0) m_tx = 1'b0;
                    else if (idx <= 9) m_tx = m_snap[idx-1];
                    else m_tx = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            checks++;
            if (uo_out !== {5'b0, m_carry, m_busy, m_tx}) begin
                errors++;
                $display("FAIL uo_out cycle %0d: got %h, required %h", cyc, uo_out,
                         {5'b0, m_carry, m_busy, m_tx});
            end
            checks++;
            if ({uio_out, uio_oe} !== 16'h0000) begin
                errors++;
                $display("FAIL uio tie-off cycle %0d: got %h, required 0000", cyc,
                         {uio_out, uio_oe});
            end
        end
    end

    // Frame capture from the wire, sampled mid-bit; bit 0 is the start bit.
    logic [10:0] frames[$];
    int          blens[$];

    initial begin : monitor
        logic        tx_prev = 1'b1;
        logic        in_frame = 1'b0;
        int          fcnt = 0;
        int          bcnt = 0;
        logic [10:0] fbits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0; bcnt = 0; tx_prev = 1'b1;
            end else begin
                if (!in_frame && tx_prev && !uo_out[0]) begin
                    in_frame = 1'b1; fcnt = 0;
                end
                if (in_frame) begin
                    if (fcnt % N == N / 2) fbits[fcnt/N] = uo_out[0];
                    if (fcnt == 10 * N + N / 2) begin
                        frames.push_back(fbits);
                        in_frame = 1'b0;
                    end
                    fcnt++;
                end
                if (uo_out[1]) bcnt++;
                else if (bcnt != 0) begin
                    blens.push_back(bcnt); bcnt = 0;
                end
                tx_prev = uo_out[0];
            end
        end
    end

    task automatic strobe(input logic [2:0] mask, input logic [7:0] val);
        @(negedge clk);
        ui_in = val;
        uio_in[2:0] = mask;
        repeat (3) @(negedge clk);
        uio_in[2:0] = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [10:0] exp);
        logic [10:0] got;
        checks++;
        if (frames.size() == 0) begin
            errors++;
            $display("FAIL %s: no frame captured, required %h", name, exp);
        end else begin
            got = frames.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h, required %h", name, got, exp);
            end
        end
    endtask

    task automatic check_busy_len(input string name);
        int got;
        checks++;
        if (blens.size() == 0) begin
            errors++;
            $display("FAIL %s: no busy pulse, required %0d cycles", name, 11 * N);
        end else begin
            got = blens.pop_front();
            if (got != 11 * N) begin
                errors++;
                $display("FAIL %s: got %0d cycles, required %0d", name, got, 11 * N);
            end
        end
    endtask

    task automatic send_and_wait();
        strobe(3'b010, ui_in);
        repeat (180) @(negedge clk);
    endtask

    initial begin : main
        ui_in = 8'h00; uio_in = 8'h00; ena = 1'b1; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("reset uo_out", uo_out, 8'h01);
        check_val("reset uio_oe", uio_oe, 8'h00);

        // Simple sum: 5 + 3 = 0x08, no carry.
        strobe(3'b001, 8'h05);
        strobe(3'b001, 8'h03);
        check_val("model acc simple", m_acc, 8'h08);
        send_and_wait();
        check_frame("frame simple", {1'b1, 1'b0, 8'h08, 1'b0});
        check_busy_len("busy simple");

        // Carry: 0xF0 + 0x20 wraps to 0x10 with sticky carry.
        strobe(3'b100, 8'h00);
        strobe(3'b001, 8'hF0);
        strobe(3'b001, 8'h20);
        check_val("carry set", {7'b0, uo_out[2]}, 8'h01);
        send_and_wait();
        check_frame("frame carry", {1'b1, 1'b1, 8'h10, 1'b0});
        check_busy_len("busy carry");
        strobe(3'b100, 8'h00);
        check_val("carry cleared", {7'b0, uo_out[2]}, 8'h00);
        send_and_wait();
        check_frame("frame after clear", {1'b1, 1'b0, 8'h00, 1'b0});

        // Activity during a frame.
        strobe(3'b001, 8'h41);
        strobe(3'b010, 8'h41);
        repeat (30) @(negedge clk);
        strobe(3'b010, 8'h41);
        strobe(3'b001, 8'h01);
        repeat (180) @(negedge clk);
        check_frame("frame in flight", {1'b1, 1'b0, 8'h41, 1'b0});
        check_busy_len("busy in flight");
        check_val("mid-frame send not queued", {7'b0, uo_out[1]}, 8'h00);
        send_and_wait();
        check_frame("frame after mid load", {1'b1, 1'b0, 8'h42, 1'b0});

        // Same-cycle strobes.
        strobe(3'b100, 8'h00);
        strobe(3'b001, 8'h10);
        strobe(3'b011, 8'h02);
        repeat (180) @(negedge clk);
        check_frame("frame send+load", {1'b1, 1'b0, 8'h10, 1'b0});
        check_val("model acc send+load", m_acc, 8'h12);
        send_and_wait();
        check_frame("frame post add", {1'b1, 1'b0, 8'h12, 1'b0});
        strobe(3'b101, 8'h55);
        check_val("model acc clear+load", m_acc, 8'h00);
        send_and_wait();
        check_frame("frame clear wins", {1'b1, 1'b0, 8'h00, 1'b0});

        // Reset mid-frame, load pin held high across release.
        strobe(3'b001, 8'h07);
        strobe(3'b010, 8'h07);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        uio_in[0] = 1'b1;
        #1 check_val("reset mid-frame uo_out", uo_out, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_val("model acc held load", m_acc, 8'h00);
        send_and_wait();
        check_frame("frame after reset", {1'b1, 1'b0, 8'h00, 1'b0});
        check_busy_len("busy after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_mrmola_sum_tx.md
# tt_um_mrmola_sum_tx

Accumulating sum transmitter for the TinyTapeout tile. Operand bytes presented on `ui_in` are added into an 8-bit running sum with a sticky carry under strobe control. On request, the sum and carry are shifted out as one UART-style serial frame on `uo_out[0]`. It is the serial-output counterpart to the tile's parallel adder: the same addition, delivered over a single wire to an off-chip receiver.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit time; legal range 2..65535.
- `clk`  in  1  tile clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  always 1 when powered; unused.
- `ui_in`  in  8  operand byte, sampled when a load is acted on.
- `uio_in`  in  8  controls, all asynchronous to `clk`:
  - `[0]` load strobe.
  - `[1]` send strobe.
  - `[2]` clear strobe.
  - `[7:3]` unused.
- `uo_out`  out  8  outputs:
  - `[0]` `tx`.
  - `[1]` `busy`.
  - `[2]` `carry`, sticky.
  - `[7:3]` tied to 0.
- `uio_out`  out  8  tied to 0.
- `uio_oe`  out  8  tied to 0; all uio pins are inputs.

## Operation
- **Strobe conditioning:** `uio_in[2:0]` each pass through a 2-flop synchronizer and a rising-edge detector. Only 0->1 transitions act; held-high levels do nothing further.
- **Load:** `acc <= acc + ui_in` (8-bit, wraps). `carry <= carry | carry_out`. `ui_in` is sampled directly in the acting cycle; the source holds it stable across the strobe.
- **Clear:** `acc <= 0`, `carry <= 0`. If clear and load act in the same cycle, clear wins and the load is dropped.
- **Send while idle:**
  - Snapshot `{carry, acc}` into a 9-bit shift register.
  - Set `busy`.
  - Frame order: start bit 0, `acc[0]`..`acc[7]` LSB first, `carry`, stop bit 1. That is 11 bit times.
- **Send while `busy`:** ignored and not queued.
- **During a frame:** load and clear operate on `acc`/`carry` normally. The frame in flight is unaffected because it transmits the snapshot.
- **Send and load in the same cycle:** the snapshot takes the pre-add value; the add still applies.
- **Send and clear in the same cycle:** the snapshot takes the pre-clear value.
- **Transmitter FSM:**
  - `IDLE`: `tx`=1. Moves to `START` on an accepted send.
  - `START`: `tx`=0 for one bit time, then `DATA`.
  - `DATA`: 9 bit times with a bit index 0..8, then `STOP`.
  - `STOP`: `tx`=1 for one bit time, then `IDLE`; `busy` clears on entering `IDLE`.
- **Bit timer:** counter from 0 to `CLKS_PER_BIT`-1, restarted on every state or bit change.
- **Reset**, asynchronous, at any time including mid-frame:
  - FSM to `IDLE`, `tx`=1, `busy`=0.
  - `acc`=0, `carry`=0, shift register=0.
  - Synchronizers and edge detectors=0, so a strobe pin held high through reset release does not act.

## Timing
- **Strobe latency:** a pin rising before clock edge k is acted on at edge k+2. The resulting `acc`/`carry` update, or `tx` falling with `busy` rising, is visible after edge k+2.
- **Frame length:** `tx` low for exactly `CLKS_PER_BIT` cycles for the start bit. Each data bit lasts `CLKS_PER_BIT` cycles, as does the stop bit. The whole frame is 11 x `CLKS_PER_BIT` cycles (176 at default).
- **`busy`:** high for exactly 11 x `CLKS_PER_BIT` cycles, falling on the same edge that ends the stop bit.
- **Back-to-back frames:** a send accepted in the first idle cycle starts the next frame, with no gap beyond the synchronizer latency.
- **Minimum strobe width:** strobes must stay low and then high for at least 2 `clk` cycles each to be detected.
- **Registered outputs:** `tx`, `busy` and `carry` come directly from flops and never glitch.

## Structure
- **Package `tt_mrmola_pkg`:**
  - FSM state enum (`IDLE`, `START`, `DATA`, `STOP`).
  - `FRAME_DATA_BITS` = 9.
  - Control bit index constants for load, send and clear.
- **Sub-module `mrmola_serial_tx`:**
  - Parameterised by `CLKS_PER_BIT`.
  - Ports: `clk`, `rst_n`, `start`, `data[8:0]`, `tx`, `busy`.
  - Holds the FSM, bit timer and shift register.
- **Top level:** synchronizers, edge detect, accumulator and output packing.

## Test plan
- **Reset:** reset, release with all strobes low -> `tx`=1, `busy`=0, `carry`=0, `uo_out`=0x01, `uio_oe`=0x00.
- **Simple sum:** load 0x05, load 0x03, send -> frame bits 0, 0,0,0,1,0,0,0,0, 0, 1 (acc 0x08, carry 0). `busy` high 176 cycles.
- **Carry:** load 0xF0, load 0x20, send -> data 0x10, carry bit 1, `uo_out[2]`=1. Clear -> `uo_out[2]`=0, next send carries 0x00 with carry 0.
- **Activity during a frame:** mid-frame send is ignored. A mid-frame load 0x01 does not alter the frame in flight; the next frame shows old acc + 1.
- **Same-cycle strobes:** send and load same cycle with acc 0x10, `ui_in` 0x02 -> frame carries 0x10, acc becomes 0x12. Clear and load same cycle -> acc 0x00.
- **Reset mid-frame:** assert `rst_n` low in the `DATA` state -> `tx`=1 and `busy`=0 immediately, acc 0. A load strobe held high across release does not act.
